// File: rtl/divisor_por_resta.sv
// divisor_por_resta: sequential unsigned divider by repeated subtraction.
// One W-bit subtractor is reused every cycle; the borrow of a (W+1)-bit
// difference decides R >= B. Start/done handshake, three-state FSM.
module divisor_por_resta #(
    parameter int unsigned W = 3
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] dividend,
    input  logic [W-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] quotient,
    output logic [W-1:0] remainder,
    output logic         div_by_zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]   state_q, state_d;
    logic [W-1:0] b_q, b_d;
    logic [W-1:0] r_q, r_d;
    logic [W-1:0] q_q, q_d;
    logic         dz_q, dz_d;

    logic [W:0]   diff;
    logic         borrow;

    // Shared subtractor: no borrow means R >= B
    always_comb begin
        diff   = {1'b0, r_q} - {1'b0, b_q};
        borrow = diff[W];
    end

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        b_d     = b_q;
        r_d     = r_q;
        q_d     = q_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    b_d  = divisor;
                    r_d  = dividend;
                    q_d  = '0;
                    dz_d = 1'b0;
                    if (divisor == '0) begin
                        // Divide by zero: report all-ones quotient and finish at once
                        q_d     = '1;
                        dz_d    = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (!borrow) begin
                    r_d = diff[W-1:0];
                    q_d = q_q + 1'b1;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            b_q     <= '0;
            r_q     <= '0;
            q_q     <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            b_q     <= b_d;
            r_q     <= r_d;
            q_q     <= q_d;
            dz_q    <= dz_d;
        end
    end

    // Outputs come straight from the registers
    always_comb begin
        busy        = (state_q == S_RUN) || (state_q == S_DONE);
        done        = (state_q == S_DONE);
        quotient    = q_q;
        remainder   = r_q;
        div_by_zero = dz_q;
    end

endmodule

// File: tb/tb_divisor_por_resta.sv
// Self-checking bench for divisor_por_resta (W=3) with an expected-result queue.
module tb_divisor_por_resta;

    localparam int unsigned W = 3;
    localparam int unsigned MAXLAT = 20;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        int unsigned q;
        int unsigned r;
        int unsigned dz;
        int unsigned lat;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    divisor_por_resta #(.W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned got, input int unsigned want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    function automatic exp_t model(input int unsigned a, input int unsigned b);
        exp_t e;
        if (b == 0) begin
            e.q = (1 << W) - 1; e.r = a; e.dz = 1; e.lat = 1;
        end else begin
            e.q = a / b; e.r = a % b; e.dz = 0; e.lat = a / b + 2;
        end
        return e;
    endfunction

    // One division; disturb scrambles inputs and pulses start while busy
    task automatic run_op(input int unsigned a, input int unsigned b, input bit disturb);
        int unsigned lat;
        int unsigned busyc;
        exp_t        e;
        @(negedge clk);
        dividend = a[W-1:0];
        divisor  = b[W-1:0];
        start    = 1'b1;
        exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 1;
        busyc = 0;
        while (lat <= MAXLAT) begin
            if (disturb) begin
                dividend = W'($urandom);
                divisor  = W'($urandom);
                start    = $urandom_range(0, 1) != 0;
            end
            if (busy) busyc++;
            if (done) break;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        e = exp_q.pop_front();
        if (!done) begin
            check_eq("done_seen", done, 1);
        end else begin
            check_eq("quotient", quotient, e.q);
            check_eq("remainder", remainder, e.r);
            check_eq("div_by_zero", div_by_zero, e.dz);
            check_eq("latency", lat, e.lat);
            check_eq("busy_cycles", busyc, e.lat);
        end
        @(posedge clk);
        #1;
        check_eq("done_pulse", done, 0);
        check_eq("busy_after", busy, 0);
        check_eq("q_hold", quotient, e.q);
        check_eq("r_hold", remainder, e.r);
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        rst      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_q", quotient, 0);
        check_eq("rst_r", remainder, 0);
        check_eq("rst_dz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;

        run_op(7, 2, 1'b0);
        run_op(3, 5, 1'b0);
        run_op(7, 0, 1'b0);
        run_op(6, 3, 1'b0);
        run_op(7, 1, 1'b1);

        // Asynchronous reset in the third RUN cycle of 7/1
        @(negedge clk);
        dividend = 3'd7;
        divisor  = 3'd1;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check_eq("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);
        check_eq("arst_q", quotient, 0);
        check_eq("arst_r", remainder, 0);
        check_eq("arst_dz", div_by_zero, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check_eq("no_done_after_rst", done, 0);
        end
        run_op(5, 2, 1'b0);

        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                run_op(a, b, 1'b0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/divisor_por_resta.md
# divisor_por_resta

Sequential unsigned divider that computes quotient and remainder by repeated subtraction. It sequences one W-bit subtractor (difference a−b, modulo 2^W) with a small FSM, a quotient counter and a remainder register. It sits beside the combinational arithmetic blocks of the sumador group and gives them a multi-cycle division operation with a start/done handshake.

## Interface
- W, default 3: operand, quotient and remainder width in bits.
- clk  input  1  system clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a division; sampled only in IDLE.
- dividend  input  W  unsigned dividend; captured on accepted start.
- divisor  input  W  unsigned divisor; captured on accepted start.
- busy  output  1  high while an operation is in progress (RUN or DONE state).
- done  output  1  one-cycle pulse; results are valid from this cycle on.
- quotient  output  W  unsigned quotient.
- remainder  output  W  unsigned remainder.
- div_by_zero  output  1  set with done when the captured divisor was 0.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - A start=1 sample is accepted. The block captures B←divisor, R←dividend and Q←0, and clears div_by_zero.
  - If divisor==0, the next state is DONE with Q←{W{1}}, R←dividend and div_by_zero←1.
  - Otherwise the next state is RUN.
- RUN, one compare per cycle:
  - If R ≥ B: R←R−B, Q←Q+1, and the FSM stays in RUN.
  - Else: the next state is DONE and R and Q are held.
- Compare and subtract:
  - R ≥ B is decided by the borrow of a (W+1)-bit difference {0,R}−{0,B}: no borrow means R ≥ B.
  - The stored value is the W-bit difference.
  - Q cannot overflow: Q ≤ dividend ≤ 2^W−1.
- DONE: done=1 for this single cycle, then the FSM returns to IDLE unconditionally.
- quotient, remainder and div_by_zero are driven straight from the registers.
  - They hold their values after done until the next accepted start.
  - On the cycle after an accepted start they show intermediate values.
- start is ignored in RUN and DONE. A start held high continuously is re-accepted in the first IDLE cycle after DONE.
- dividend and divisor may change freely after the accepting edge.

## Timing
- Reset (rst=1, asynchronous): state←IDLE. busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
- Reset asserted mid-operation aborts immediately. No done pulse is produced and outputs go to their reset values.
- The first accepting edge is the first rising edge with rst=0 and start=1 in IDLE.
- Let edge 0 be the accepting edge.
  - Normal case: RUN occupies Q+1 cycles, and done is high in the cycle following edge Q+1. Latency from start sample to done = Q+2 cycles. busy stays high for those Q+2 cycles.
  - Divisor 0: done is high in the cycle following edge 0, so latency = 1 cycle.
- Worst case is dividend=2^W−1 with divisor=1, giving latency 2^W+1 (9 cycles for W=3).
- busy falls in the same cycle that the FSM re-enters IDLE, which is the cycle after done.
- Back-to-back operation: a new start can be accepted on the edge that ends the first IDLE cycle after DONE.

## Test plan
- W=3, 7÷2, single-cycle start: done high exactly 5 cycles after the start sample; quotient=3, remainder=1, div_by_zero=0; busy high for 5 cycles.
- 3÷5: done after 2 cycles; quotient=0, remainder=3.
- 7÷0: done after 1 cycle; div_by_zero=1, quotient=7, remainder=7. Then 6÷3: done after 4 cycles with quotient=2, remainder=0, div_by_zero=0.
- 7÷1 (worst case): done after 9 cycles with quotient=7, remainder=0. Changing dividend/divisor and pulsing start during busy must not alter the result or timing.
- Assert rst asynchronously (between edges) in the 3rd RUN cycle of 7÷1: all outputs are 0 immediately and no done follows. After release, 5÷2 gives quotient=2, remainder=1 in 4 cycles.
- Exhaustive: all 64 dividend/divisor pairs at W=3, checked against the reference model q=a/b, r=a%b (b=0 → q=7, r=a, div_by_zero=1). The latency of every case must equal q+2, or 1 when b=0.
